// File: rtl/sr_pulse_driver.sv
// SR latch command driver: one fixed-width S or R pulse per accepted command, then a quiet gap.
// Pulse starts the edge after accept; cmd_ready stays low for PULSE_W+GAP_W cycles. Optional readback check under SR_DRV_READBACK_EN.
module sr_pulse_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic S,
    output logic R,
    output logic q_exp,
    output logic busy
`ifdef SR_DRV_READBACK_EN
    ,
    input  logic q_fb,
    output logic err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_LD   = (GAP_W > 0) ? 8'(GAP_W - 1) : 8'd0;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_type;
    logic       r_s;
    logic       r_r;
    logic       r_q_exp;
    logic       r_ready;
    logic       r_busy;
    logic       w_pulse_done;

    assign w_pulse_done = (r_state == ST_PULSE) && (r_cnt == 8'd0);

    // S and R are only ever loaded as complements or both zero, so S&&R cannot occur.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_type  <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_q_exp <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_state <= ST_PULSE;
                        r_type  <= cmd_set;
                        r_cnt   <= PULSE_LD;
                        r_s     <= cmd_set;
                        r_r     <= !cmd_set;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (w_pulse_done) begin
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_q_exp <= r_type;
                        r_cnt   <= GAP_LD;
                        if (GAP_W > 0) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign S         = r_s;
    assign R         = r_r;
    assign q_exp     = r_q_exp;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;

`ifdef SR_DRV_READBACK_EN
    logic [1:0] r_fb_sync;
    logic [1:0] r_idle_cnt;
    logic       r_chk_en;
    logic       r_err;

    // Compare only after the latch output has been settled in IDLE for a few cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fb_sync  <= 2'b00;
            r_idle_cnt <= 2'd0;
            r_chk_en   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_fb_sync <= {r_fb_sync[0], q_fb};
            if (r_state != ST_IDLE) begin
                r_idle_cnt <= 2'd0;
            end else if (r_idle_cnt != 2'd3) begin
                r_idle_cnt <= r_idle_cnt + 2'd1;
            end
            if (w_pulse_done) begin
                r_chk_en <= 1'b1;
            end
            if ((r_state == ST_IDLE) && (r_idle_cnt == 2'd3) && r_chk_en &&
                (r_fb_sync[1] != r_q_exp)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver: (4,2) and (1,0) instances, plus readback when SR_DRV_READBACK_EN is defined.
module tb_sr_pulse_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v1 = 1'b0, s1 = 1'b0, v2 = 1'b0, s2 = 1'b0;
    logic S1, R1, q1, rdy1, busy1;
    logic S2, R2, q2, rdy2, busy2;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

`ifdef SR_DRV_READBACK_EN
    logic err1, err2;
    logic lat_q = 1'b0;
    logic force_low = 1'b0;
    always @(S1 or R1 or force_low) begin
        if (force_low) lat_q = 1'b0;
        else if (S1)   lat_q = 1'b1;
        else if (R1)   lat_q = 1'b0;
    end
`endif

    sr_pulse_driver #(.PULSE_W(4), .GAP_W(2)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_set(s1), .cmd_ready(rdy1),
        .S(S1), .R(R1), .q_exp(q1), .busy(busy1)
`ifdef SR_DRV_READBACK_EN
        , .q_fb(lat_q), .err(err1)
`endif
    );

    sr_pulse_driver #(.PULSE_W(1), .GAP_W(0)) u_min (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_set(s2), .cmd_ready(rdy2),
        .S(S2), .R(R2), .q_exp(q2), .busy(busy2)
`ifdef SR_DRV_READBACK_EN
        , .q_fb(S2 ? 1'b1 : (R2 ? 1'b0 : q2)), .err(err2)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b0;
        v2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({S1, R1, q1, rdy1, busy1} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_main: {S,R,q_exp,rdy,busy} got %b want 00010", {S1, R1, q1, rdy1, busy1});
        end
        checks++;
        if ({S2, R2, q2, rdy2, busy2} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_min: {S,R,q_exp,rdy,busy} got %b want 00010", {S2, R2, q2, rdy2, busy2});
        end
        rst = 1'b0;
    endtask

    task automatic test_set();
        logic [4:0] exp;
        v1 = 1'b1;
        s1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {(i <= 3), 1'b0, (i >= 4), (i >= 6), (i < 6)};
            checks++;
            if ({S1, R1, q1, rdy1, busy1} !== exp) begin
                errors++;
                $display("FAIL set_cyc%0d: {S,R,q_exp,rdy,busy} got %b want %b", i, {S1, R1, q1, rdy1, busy1}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        logic       rdy_e;
        v1 = 1'b1;
        s1 = 1'b1;
        @(posedge clk);
        #1;
        s1 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rdy_e = (i == 6) || (i >= 13);
            exp = {(i <= 3), (i >= 7 && i <= 10), (i < 11), rdy_e, !rdy_e};
            checks++;
            if ({S1, R1, q1, rdy1, busy1} !== exp) begin
                errors++;
                $display("FAIL b2b_cyc%0d: {S,R,q_exp,rdy,busy} got %b want %b", i, {S1, R1, q1, rdy1, busy1}, exp);
            end
            if (i == 7) v1 = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midpulse();
        logic seen;
        v1 = 1'b1;
        s1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({S1, q1} !== 2'b11) begin
            errors++;
            $display("FAIL midpulse_pre: {S,q_exp} got %b want 11", {S1, q1});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({S1, R1, q1, rdy1, busy1} !== 5'b00010) begin
            errors++;
            $display("FAIL midpulse_rst: {S,R,q_exp,rdy,busy} got %b want 00010", {S1, R1, q1, rdy1, busy1});
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | S1 | R1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midpulse_nopulse: pulse seen got %b want 0", seen);
        end
    endtask

    task automatic test_min_gap();
        logic [4:0] exp;
        v2 = 1'b1;
        s2 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            exp = {(i % 4 == 0), (i % 4 == 2), (i % 4 == 1) || (i % 4 == 2), (i % 2 == 1), (i % 2 == 0)};
            checks++;
            if ({S2, R2, q2, rdy2, busy2} !== exp) begin
                errors++;
                $display("FAIL mingap_cyc%0d: {S,R,q_exp,rdy,busy} got %b want %b", i, {S2, R2, q2, rdy2, busy2}, exp);
            end
            if (i % 4 == 0) s2 = 1'b0;
            if (i % 4 == 2) s2 = 1'b1;
            @(posedge clk);
            #1;
        end
        v2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic m_busy = 1'b0, m_q = 1'b1, m_type = 1'b1, m_s = 1'b0, m_r = 1'b0;
        int   mism = 0;
        int   overlap = 0;
        for (int n = 0; n < 4000; n++) begin
            v1 = 1'($urandom_range(0, 1));
            s1 = 1'($urandom_range(0, 1));
            v2 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (m_busy) begin
                m_busy = 1'b0;
                m_s = 1'b0;
                m_r = 1'b0;
                m_q = m_type;
            end else if (v2) begin
                m_busy = 1'b1;
                m_type = s2;
                m_s = s2;
                m_r = !s2;
            end
            #1;
            if ({S2, R2, q2, rdy2} !== {m_s, m_r, m_q, !m_busy}) mism++;
            if (S1 && R1) overlap++;
            if (S2 && R2) overlap++;
        end
        v1 = 1'b0;
        v2 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL random_model: mismatching cycles got %0d want 0", mism);
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL random_s_and_r: overlap cycles got %0d want 0", overlap);
        end
    endtask

`ifdef SR_DRV_READBACK_EN
    task automatic test_readback();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL rb_reset: err got %b want 0", err1);
        end
        v1 = 1'b1;
        s1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if ({q1, err1} !== 2'b10) begin
            errors++;
            $display("FAIL rb_good: {q_exp,err} got %b want 10", {q1, err1});
        end
        force_low = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL rb_detect: err got %b want 1", err1);
        end
        force_low = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL rb_sticky: err got %b want 1", err1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL rb_clear: err got %b want 0", err1);
        end
    endtask
`endif

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_set();
        test_back_to_back();
        test_reset_midpulse();
        test_min_gap();
        test_random();
`ifdef SR_DRV_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
